// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - two-requester register-file write arbiter with post-reset clearing
module reg_write_arbiter #(
  parameter int CLEAR_ON_RESET = 1,
  parameter int XLEN           = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [4:0]      a_addr,
  input  logic [XLEN-1:0] a_data,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [4:0]      b_addr,
  input  logic [XLEN-1:0] b_data,
  output logic            reg_file_wr_en,
  output logic [4:0]      wr_addr,
  output logic [XLEN-1:0] data_in,
  output logic            init_busy
);

  typedef enum logic {CLEAR, RUN} state_t;

  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;

  state_t     state, state_next;
  logic [4:0] clr_cnt;
  logic       ptr;          // 0: A wins contention next, 1: B wins
  logic       clear_done;

  // The x31 strobe is on the outputs; commit it and hand over to RUN.
  assign clear_done = reg_file_wr_en && (wr_addr == 5'd31);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RESET_STATE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    a_ready    = 1'b0;
    b_ready    = 1'b0;
    init_busy  = 1'b0;
    case (state)
      CLEAR: begin
        init_busy = 1'b1;
        if (clear_done) state_next = RUN;
      end
      RUN: begin
        // rst_n gating keeps readies low during reset when clearing is disabled
        a_ready = rst_n && a_valid && (!b_valid || !ptr);
        b_ready = rst_n && b_valid && (!a_valid ||  ptr);
      end
      default: state_next = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt        <= 5'd1;
      ptr            <= 1'b0;
      reg_file_wr_en <= 1'b0;
      wr_addr        <= 5'd0;
      data_in        <= '0;
    end else if (state == CLEAR) begin
      if (clear_done) begin
        reg_file_wr_en <= 1'b0;
      end else begin
        reg_file_wr_en <= 1'b1;
        wr_addr        <= clr_cnt;
        data_in        <= '0;
        clr_cnt        <= clr_cnt + 5'd1;
      end
    end else begin
      reg_file_wr_en <= 1'b0;
      // x0 requests handshake normally but never strobe the write port
      if (a_ready) begin
        reg_file_wr_en <= (a_addr != 5'd0);
        if (a_addr != 5'd0) begin
          wr_addr <= a_addr;
          data_in <= a_data;
        end
      end else if (b_ready) begin
        reg_file_wr_en <= (b_addr != 5'd0);
        if (b_addr != 5'd0) begin
          wr_addr <= b_addr;
          data_in <= b_data;
        end
      end
      if (a_valid && b_valid) ptr <= ~ptr;
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - self-checking bench for reg_write_arbiter with reference model
module tb_reg_write_arbiter;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            a_valid, b_valid;
  logic            a_ready, b_ready;
  logic [4:0]      a_addr, b_addr;
  logic [XLEN-1:0] a_data, b_data;
  logic            reg_file_wr_en;
  logic [4:0]      wr_addr;
  logic [XLEN-1:0] data_in;
  logic            init_busy;

  int errors = 0;
  int checks = 0;

  reg_write_arbiter #(.CLEAR_ON_RESET(1), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .reg_file_wr_en(reg_file_wr_en), .wr_addr(wr_addr), .data_in(data_in),
    .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  // Register file attached to the write port
  logic [XLEN-1:0] rf [32];
  logic            preload = 1'b0;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) rf[i] <= (i == 0) ? '0 : (32'hA5A5_0000 | 32'(i));
    end else if (reg_file_wr_en && wr_addr != 5'd0) begin
      rf[wr_addr] <= data_in;
    end
  end

  // Reference model: who wins the next contention, expected write port, expected file
  int              rr_next;
  logic            exp_en;
  logic [4:0]      exp_addr;
  logic [XLEN-1:0] exp_data;
  logic [XLEN-1:0] exp_rf [32];

  task automatic arb(input logic av, input logic bv, output int g);
    if (av && bv) begin
      g = (rr_next == 0) ? 1 : 2;
      rr_next = 1 - rr_next;
    end else if (av) g = 1;
    else if (bv) g = 2;
    else g = 0;
  endtask

  task automatic model_accept(input int g);
    logic [4:0]      ad;
    logic [XLEN-1:0] dd;
    ad = (g == 1) ? a_addr : b_addr;
    dd = (g == 1) ? a_data : b_data;
    if (g != 0 && ad != 5'd0) begin
      exp_en = 1'b1; exp_addr = ad; exp_data = dd; exp_rf[ad] = dd;
    end else begin
      exp_en = 1'b0;
    end
  endtask

  task automatic test_reset;
    a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h1234;
    b_valid = 1'b1; b_addr = 5'd10; b_data = 32'h5678;
    rst_n = 1'b0; preload = 1'b1;
    @(negedge clk); @(negedge clk);
    preload = 1'b0;
    checks++;
    if ({reg_file_wr_en, wr_addr, data_in, a_ready, b_ready, init_busy} !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1})
      $display("FAIL reset_state: got en=%b addr=%0d data=%h ar=%b br=%b busy=%b expected 0 0 0 0 0 1",
               reg_file_wr_en, wr_addr, data_in, a_ready, b_ready, init_busy);
      errors += ({reg_file_wr_en, wr_addr, data_in, a_ready, b_ready, init_busy} !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1}) ? 1 : 0;
  endtask

  task automatic test_clear;
    int g;
    int bad;
    a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h77; b_valid = 1'b0;
    rst_n = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      @(negedge clk);
      checks++;
      if ({reg_file_wr_en, wr_addr, data_in, init_busy, a_ready, b_ready} !== {1'b1, 5'(k), 32'd0, 1'b1, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL clear_strobe: got en=%b addr=%0d data=%h busy=%b ar=%b br=%b expected 1 %0d 0 1 0 0",
                 reg_file_wr_en, wr_addr, data_in, init_busy, a_ready, b_ready, k);
      end
    end
    @(negedge clk);
    checks++;
    if ({init_busy, reg_file_wr_en, a_ready, b_ready} !== 4'b0010) begin
      errors++;
      $display("FAIL first_run_cycle: got busy=%b en=%b ar=%b br=%b expected 0 0 1 0",
               init_busy, reg_file_wr_en, a_ready, b_ready);
    end
    bad = 0;
    for (int i = 0; i < 32; i++) if (rf[i] !== '0) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL cleared_file: got %0d nonzero registers expected 0", bad);
    end
    rr_next = 0;
    for (int i = 0; i < 32; i++) exp_rf[i] = '0;
    exp_en = 1'b0; exp_addr = 5'd31; exp_data = '0;
    arb(a_valid, b_valid, g);
    model_accept(g);
    @(negedge clk);
    checks++;
    if ({reg_file_wr_en, wr_addr, data_in} !== {1'b1, 5'd7, 32'h77}) begin
      errors++;
      $display("FAIL held_during_clear: got en=%b addr=%0d data=%h expected 1 7 77",
               reg_file_wr_en, wr_addr, data_in);
    end
    a_valid = 1'b0;
    model_accept(0);
    @(negedge clk);
  endtask

  task automatic test_single_write;
    int g;
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'd3; b_valid = 1'b0;
    #1;
    checks++;
    if ({a_ready, b_ready} !== 2'b10) begin
      errors++;
      $display("FAIL single_ready: got ar=%b br=%b expected 1 0", a_ready, b_ready);
    end
    arb(a_valid, b_valid, g);
    model_accept(g);
    @(negedge clk);
    checks++;
    if ({reg_file_wr_en, wr_addr, data_in} !== {1'b1, 5'd3, 32'd3}) begin
      errors++;
      $display("FAIL single_write: got en=%b addr=%0d data=%h expected 1 3 3", reg_file_wr_en, wr_addr, data_in);
    end
    a_valid = 1'b0;
    model_accept(0);
    @(negedge clk);
    checks++;
    if (rf[3] !== 32'd3 || {reg_file_wr_en, wr_addr} !== {1'b0, 5'd3}) begin
      errors++;
      $display("FAIL single_commit: got x3=%h en=%b addr=%0d expected 3 0 3", rf[3], reg_file_wr_en, wr_addr);
    end
  endtask

  task automatic test_back_to_back;
    int g;
    int na = 0;
    int nb = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin
        checks++;
        if ({reg_file_wr_en, wr_addr, data_in} !== {exp_en, exp_addr, exp_data}) begin
          errors++;
          $display("FAIL b2b_write: got en=%b addr=%0d data=%h expected %b %0d %h",
                   reg_file_wr_en, wr_addr, data_in, exp_en, exp_addr, exp_data);
        end
      end
      a_valid = 1'b1; a_addr = 5'd4; a_data = 32'h0000_F0F0 + 32'(na);
      b_valid = 1'b1; b_addr = 5'd5; b_data = 32'h0000_00F0 + 32'(nb);
      #1;
      checks++;
      if ({a_ready, b_ready} !== {(i % 2 == 0), (i % 2 == 1)}) begin
        errors++;
        $display("FAIL b2b_alternate: cycle %0d got ar=%b br=%b expected %b %b",
                 i, a_ready, b_ready, (i % 2 == 0), (i % 2 == 1));
      end
      arb(1'b1, 1'b1, g);
      model_accept(g);
      if (g == 1) na++; else nb++;
      @(negedge clk);
    end
    checks++;
    if ({reg_file_wr_en, wr_addr, data_in} !== {1'b1, 5'd5, 32'h0000_00F4}) begin
      errors++;
      $display("FAIL b2b_last: got en=%b addr=%0d data=%h expected 1 5 000000f4", reg_file_wr_en, wr_addr, data_in);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    model_accept(0);
    @(negedge clk);
    checks++;
    if (rf[4] !== 32'h0000_F0F4 || rf[5] !== 32'h0000_00F4) begin
      errors++;
      $display("FAIL b2b_commit: got x4=%h x5=%h expected 0000f0f4 000000f4", rf[4], rf[5]);
    end
  endtask

  task automatic test_addr_zero;
    int g;
    logic [4:0]      prev_addr;
    logic [XLEN-1:0] prev_data;
    prev_addr = exp_addr; prev_data = exp_data;
    b_valid = 1'b1; b_addr = 5'd0; b_data = 32'hFFFF_FFFF; a_valid = 1'b0;
    #1;
    checks++;
    if ({a_ready, b_ready} !== 2'b01) begin
      errors++;
      $display("FAIL x0_ready: got ar=%b br=%b expected 0 1", a_ready, b_ready);
    end
    arb(a_valid, b_valid, g);
    model_accept(g);
    @(negedge clk);
    b_valid = 1'b0;
    checks++;
    if ({reg_file_wr_en, wr_addr, data_in} !== {1'b0, prev_addr, prev_data}) begin
      errors++;
      $display("FAIL x0_no_strobe: got en=%b addr=%0d data=%h expected 0 %0d %h",
               reg_file_wr_en, wr_addr, data_in, prev_addr, prev_data);
    end
    model_accept(0);
    @(negedge clk);
    checks++;
    if (rf[0] !== '0) begin
      errors++;
      $display("FAIL x0_zero: got x0=%h expected 0", rf[0]);
    end
  endtask

  task automatic test_random(input int n);
    int   g;
    int   bad;
    logic pa = 1'b0;
    logic pb = 1'b0;
    for (int i = 0; i < n; i++) begin
      checks++;
      if ({reg_file_wr_en, wr_addr, data_in} !== {exp_en, exp_addr, exp_data}) begin
        errors++;
        $display("FAIL rand_write: cycle %0d got en=%b addr=%0d data=%h expected %b %0d %h",
                 i, reg_file_wr_en, wr_addr, data_in, exp_en, exp_addr, exp_data);
      end
      if (!pa && ($urandom_range(0, 2) != 0)) begin
        pa = 1'b1; a_addr = 5'($urandom_range(0, 7)); a_data = $urandom;
      end
      if (!pb && ($urandom_range(0, 2) != 0)) begin
        pb = 1'b1; b_addr = 5'($urandom_range(0, 7)); b_data = $urandom;
      end
      a_valid = pa; b_valid = pb;
      #1;
      arb(pa, pb, g);
      checks++;
      if ({a_ready, b_ready} !== {(g == 1), (g == 2)}) begin
        errors++;
        $display("FAIL rand_grant: cycle %0d got ar=%b br=%b expected %b %b",
                 i, a_ready, b_ready, (g == 1), (g == 2));
      end
      model_accept(g);
      if (g == 1) pa = 1'b0;
      if (g == 2) pb = 1'b0;
      @(negedge clk);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    checks++;
    if ({reg_file_wr_en, wr_addr, data_in} !== {exp_en, exp_addr, exp_data}) begin
      errors++;
      $display("FAIL rand_tail: got en=%b addr=%0d data=%h expected %b %0d %h",
               reg_file_wr_en, wr_addr, data_in, exp_en, exp_addr, exp_data);
    end
    model_accept(0);
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 32; i++) if (rf[i] !== exp_rf[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rand_file: got %0d registers differing from model expected 0", bad);
    end
  endtask

  task automatic test_mid_reset;
    a_valid = 1'b1; a_addr = 5'd6; a_data = 32'h0000_00F0; b_valid = 1'b0;
    #1;
    checks++;
    if (a_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_grant: got ar=%b expected 1", a_ready);
    end
    @(posedge clk);
    #2;
    checks++;
    if ({reg_file_wr_en, wr_addr} !== {1'b1, 5'd6}) begin
      errors++;
      $display("FAIL midrst_inflight: got en=%b addr=%0d expected 1 6", reg_file_wr_en, wr_addr);
    end
    rst_n = 1'b0;
    a_valid = 1'b0;
    #1;
    checks++;
    if ({reg_file_wr_en, wr_addr, data_in, a_ready, b_ready, init_busy} !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL midrst_async: got en=%b addr=%0d data=%h ar=%b br=%b busy=%b expected 0 0 0 0 0 1",
               reg_file_wr_en, wr_addr, data_in, a_ready, b_ready, init_busy);
    end
    @(posedge clk);
    #1;
    checks++;
    if (rf[6] !== exp_rf[6]) begin
      errors++;
      $display("FAIL midrst_x6: got x6=%h expected %h", rf[6], exp_rf[6]);
    end
    preload = 1'b1;
    @(posedge clk);
    #1;
    preload = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    a_valid = 1'b0; b_valid = 1'b0;
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
    test_reset;
    test_clear;
    test_single_write;
    test_back_to_back;
    test_addr_zero;
    test_random(400);
    test_mid_reset;
    test_clear;
    test_random(200);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 SHALL have parameter CLEAR_ON_RESET, default 1, meaning 1 = zero x1..x31 after reset and 0 = skip clearing.
REQ-002 SHALL have parameter XLEN, default 32, meaning write data width.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port a_valid  in  1  ALU writeback request.
REQ-006 SHALL have port a_ready  out  1  ALU request accepted this cycle when high with a_valid.
REQ-007 SHALL have ports a_addr  in  5  and a_data  in  XLEN  ALU destination register and value.
REQ-008 SHALL have ports b_valid  in  1, b_ready  out  1, b_addr  in  5, b_data  in  XLEN  load-unit writeback, with the same semantics as port A.
REQ-009 SHALL have ports reg_file_wr_en  out  1, wr_addr  out  5, data_in  out  XLEN  driving the register file's single write port.
REQ-010 SHALL have port init_busy  out  1  high while clearing is in progress.

Function
REQ-011 SHALL implement a state machine with two states: CLEAR and RUN.
REQ-012 In CLEAR, SHALL present one write per cycle: reg_file_wr_en=1, data_in=0, wr_addr counting 1..31.
REQ-013 In CLEAR, SHALL leave the state on the cycle after the wr_addr=31 strobe and enter RUN; CLEAR lasts exactly 31 cycles.
REQ-014 If CLEAR_ON_RESET=0, SHALL enter RUN directly from reset.
REQ-015 In CLEAR, SHALL hold a_ready=0, b_ready=0 and init_busy=1; in RUN, SHALL hold init_busy=0.
REQ-016 In RUN, SHALL accept at most one request per cycle; a handshake is valid&&ready sampled at a rising edge.
REQ-017 When only one requester is valid, SHALL assert that requester's ready and hold the other's ready at 0.
REQ-018 When both are valid, SHALL grant by round-robin: the priority pointer starts at A and flips to the other requester after every contended grant.
REQ-019 SHALL leave the pointer unchanged on uncontended grants.
REQ-020 ready SHALL be a combinational function of the valids, the pointer and the state only; it SHALL NOT depend on the data or address inputs.
REQ-021 The write output SHALL be registered: a request accepted at edge N appears on reg_file_wr_en/wr_addr/data_in during cycle N+1 and commits at edge N+2.
REQ-022 With back-to-back grants, SHALL sustain one write per cycle.
REQ-023 SHALL complete the handshake for a request with addr=0 but SHALL NOT strobe reg_file_wr_en for it (x0 stays zero).
REQ-024 SHALL set reg_file_wr_en=0 in any RUN cycle following an edge with no accepted nonzero-address request; wr_addr and data_in then hold their previous values.
REQ-025 A requester SHALL hold valid, addr and data stable until accepted; the arbiter SHALL NOT drop or reorder accepted requests.
REQ-026 A request for the same address from both requesters in one cycle SHALL be treated as an ordinary contended grant; the loser is written on a later cycle.

Reset
REQ-027 rst_n=0 SHALL immediately, without waiting for a clock edge, force: state=CLEAR (or RUN if CLEAR_ON_RESET=0), clear counter=1, pointer=A, reg_file_wr_en=0, wr_addr=0, data_in=0, a_ready=0, b_ready=0.
REQ-028 init_busy SHALL equal CLEAR_ON_RESET during reset.
REQ-029 Reset asserted mid-CLEAR or mid-RUN SHALL abort in-flight writes, and clearing SHALL restart from x1 after release.
REQ-030 The first CLEAR strobe (wr_addr=1) SHALL appear in the first cycle after rst_n rises.

Verification
REQ-031 Release reset (CLEAR_ON_RESET=1), preload the register file with nonzero values -> 31 strobes addr 1..31 data 0, then init_busy=0, and all registers read 0.
REQ-032 In RUN, assert a_valid alone with addr=3, data=3 -> a_ready=1; one cycle later wr_en=1, wr_addr=3, data_in=3; reading x3 returns 3.
REQ-033 Hold a_valid and b_valid continuously (A: x4=0000F0F0, B: x5=000000F0, new data each accept) -> grants alternate A,B,A,B; writes occur one per cycle.
REQ-034 Send b_valid with addr=0, data=FFFFFFFF -> b_ready=1, reg_file_wr_en stays 0, x0 reads 0.
REQ-035 Assert rst_n=0 in the middle of a granted A write (x6=F0) -> outputs go to 0 asynchronously; x6 is not written; clearing restarts at addr 1.
REQ-036 Raise a_valid during CLEAR -> a_ready=0 until RUN; request accepted in the first RUN cycle.
